// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with oversampling, 3-sample
// majority vote, parity/framing/break/overrun reporting and a valid/ready
// output.
// Build option: define UART_RX_FIFO_EN to place a FIFO_DEPTH-entry FIFO
// (FIFO_DEPTH >= 2, power of 2) in front of the output. Without it the
// output is a single holding register.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | line idle, waiting for a tick that sees the line low
// S_START  | inside the start bit, confirming it at mid-bit
// S_DATA   | sampling DATA_BITS data bits, LSB first
// S_PARITY | sampling the parity bit (only when PARITY != 0)
// S_STOP   | sampling STOP_BITS stop bits; detects break on the first
// S_BREAK  | line held low after a break; waits for the line to go high
module uart_rx_param #(
  parameter int CLK_DIV    = 27,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_overrun,
  output logic                 rx_break,
  output logic                 rx_busy
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int PW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] TICK_LAST = CW'(CLK_DIV - 1);
  localparam logic [PW-1:0] SAMPLE_PH = PW'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic          PAR_ODD   = (PARITY == 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_e;

  logic sync1_q, sync2_q;
  logic [CW-1:0] div_q;
  logic tick;
  logic [1:0] hist_q;
  logic [2:0] window;
  logic vote;
  logic sample_pt;

  state_e state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [3:0] bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic par_bit_q, par_bit_d;
  logic perr_q, perr_d;
  logic ferr_q, ferr_d;
  logic done_q, done_d;
  logic brk_q, brk_d;

  // Two-flop synchroniser for the asynchronous line; idles high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rxd;
      sync2_q <= sync1_q;
    end
  end

  // Free-running oversample tick divider.
  assign tick = (div_q == TICK_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) div_q <= '0;
    else        div_q <= tick ? '0 : div_q + 1'b1;
  end

  // Sample history: the vote window is the two previous tick samples
  // plus the current one, so the vote is centred one tick before the
  // sample point.
  assign window = {hist_q, sync2_q};
  assign vote   = (window[0] & window[1]) | (window[0] & window[2]) |
                  (window[1] & window[2]);
  assign sample_pt = tick && (phase_q == SAMPLE_PH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    hist_q <= 2'b11;
    else if (tick) hist_q <= {hist_q[0], sync2_q};
  end

  // Receive state and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      phase_q   <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      par_bit_q <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      done_q    <= 1'b0;
      brk_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      par_bit_q <= par_bit_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      done_q    <= done_d;
      brk_q     <= brk_d;
    end
  end

  // Next-state logic: all actions happen on ticks, bit decisions at the
  // mid-bit sample point.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    par_bit_d = par_bit_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    done_d    = 1'b0;
    brk_d     = 1'b0;
    if (tick) phase_d = phase_q + 1'b1;
    case (state_q)
      S_IDLE: begin
        if (tick && !sync2_q) begin
          state_d = S_START;
          phase_d = '0;
        end
      end
      S_START: begin
        if (sample_pt) begin
          if (vote) begin
            state_d = S_IDLE;
          end else begin
            state_d   = S_DATA;
            bit_d     = '0;
            par_bit_d = 1'b0;
            perr_d    = 1'b0;
            ferr_d    = 1'b0;
          end
        end
      end
      S_DATA: begin
        if (sample_pt) begin
          shift_d = {vote, shift_q[DATA_BITS-1:1]};
          if (bit_q == DATA_LAST) begin
            bit_d   = '0;
            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (sample_pt) begin
          par_bit_d = vote;
          perr_d    = (vote != ((^shift_q) ^ PAR_ODD));
          state_d   = S_STOP;
        end
      end
      S_STOP: begin
        if (sample_pt) begin
          if (bit_q == '0 && !vote && shift_q == '0 && !par_bit_q) begin
            brk_d   = 1'b1;
            state_d = S_BREAK;
          end else begin
            if (!vote) ferr_d = 1'b1;
            if (bit_q == STOP_LAST) begin
              // Leave mid-stop-bit so the next start edge is seen promptly.
              done_d  = 1'b1;
              state_d = S_IDLE;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end
        end
      end
      S_BREAK: begin
        if (tick && sync2_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rx_busy  = (state_q != S_IDLE);
  assign rx_break = brk_q;

`ifdef UART_RX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef logic [DATA_BITS+1:0] entry_t;

  entry_t mem_q [FIFO_DEPTH];
  logic [AW:0] wr_q, rd_q;
  logic empty, full, pop, push, ovr_q;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop   = !empty && rx_ready;
  assign push  = done_q && (!full || pop);

  // FIFO storage; a push into a full FIFO only happens alongside a pop,
  // which frees the head slot being overwritten.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q[AW-1:0]] <= {shift_q, perr_q, ferr_q};
  end

  // FIFO pointers and overrun pulse for frames that find no room.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      ovr_q <= 1'b0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      ovr_q <= done_q && full && !pop;
    end
  end

  assign rx_valid   = !empty;
  assign rx_overrun = ovr_q;
  assign {rx_data, rx_parity_err, rx_frame_err} = empty ? '0 : mem_q[rd_q[AW-1:0]];
`else
  logic [DATA_BITS-1:0] data_q;
  logic pe_q, fe_q, valid_q, ovr_q;
  logic unused_depth;

  assign unused_depth = (FIFO_DEPTH > 0);

  // Single holding register; a frame arriving while the word is unclaimed
  // is dropped, unless the word is being accepted in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      pe_q    <= 1'b0;
      fe_q    <= 1'b0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      ovr_q <= 1'b0;
      if (done_q) begin
        if (valid_q && !rx_ready) begin
          ovr_q <= 1'b1;
        end else begin
          data_q  <= shift_q;
          pe_q    <= perr_q;
          fe_q    <= ferr_q;
          valid_q <= 1'b1;
        end
      end else if (valid_q && rx_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign rx_data       = data_q;
  assign rx_parity_err = pe_q;
  assign rx_frame_err  = fe_q;
  assign rx_valid      = valid_q;
  assign rx_overrun    = ovr_q;
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: one 8N1 receiver and one 8E2 receiver, both at
// CLK_DIV=4 / OVERSAMPLE=8 (32 clk per bit). Expected words come from a
// frame-level model (data, parity by ones-count, stop-bit levels).
`timescale 1ns/1ps
module tb_uart_rx_param;
  localparam int CLK_DIV = 4;
  localparam int OS      = 8;
  localparam int BIT_CLK = CLK_DIV * OS;
`ifdef UART_RX_FIFO_EN
  localparam int OVR_FRAMES = 5;
  localparam int KEEP       = 4;
`else
  localparam int OVR_FRAMES = 2;
  localparam int KEEP       = 1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic rxd_n = 1'b1, rdy_n = 1'b1;
  logic [7:0] data_n;
  logic pe_n, fe_n, v_n, ov_n, bk_n, busy_n;

  logic rxd_e = 1'b1, rdy_e = 1'b1;
  logic [7:0] data_e;
  logic pe_e, fe_e, v_e, ov_e, bk_e, busy_e;

  int checks = 0;
  int failures = 0;
  int cnt_ovr_n = 0, cnt_brk_n = 0, cnt_ovr_e = 0, cnt_brk_e = 0;
  logic [9:0] acc_n[$];
  logic [9:0] acc_e[$];

  always #5 clk = ~clk;

  uart_rx_param #(.CLK_DIV(CLK_DIV), .OVERSAMPLE(OS), .DATA_BITS(8), .PARITY(0),
                  .STOP_BITS(1), .FIFO_DEPTH(4)) dut_n (
    .clk(clk), .rst_n(rst_n), .rxd(rxd_n), .rx_data(data_n),
    .rx_parity_err(pe_n), .rx_frame_err(fe_n), .rx_valid(v_n), .rx_ready(rdy_n),
    .rx_overrun(ov_n), .rx_break(bk_n), .rx_busy(busy_n));

  uart_rx_param #(.CLK_DIV(CLK_DIV), .OVERSAMPLE(OS), .DATA_BITS(8), .PARITY(2),
                  .STOP_BITS(2), .FIFO_DEPTH(4)) dut_e (
    .clk(clk), .rst_n(rst_n), .rxd(rxd_e), .rx_data(data_e),
    .rx_parity_err(pe_e), .rx_frame_err(fe_e), .rx_valid(v_e), .rx_ready(rdy_e),
    .rx_overrun(ov_e), .rx_break(bk_e), .rx_busy(busy_e));

  // Record accepted words and count pulse cycles.
  always @(posedge clk) begin
    if (v_n && rdy_n) acc_n.push_back({pe_n, fe_n, data_n});
    if (v_e && rdy_e) acc_e.push_back({pe_e, fe_e, data_e});
    if (ov_n) cnt_ovr_n++;
    if (bk_n) cnt_brk_n++;
    if (ov_e) cnt_ovr_e++;
    if (bk_e) cnt_brk_e++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_line(input bit e, input logic v);
    if (e) rxd_e = v;
    else   rxd_n = v;
  endtask

  task automatic idle(input int nbits);
    repeat (nbits * BIT_CLK) @(negedge clk);
  endtask

  // Drive one whole frame, LSB first; returns at the end of the last stop bit.
  task automatic send(input bit e, input logic [7:0] d, input logic p, input logic [1:0] stp);
    logic [11:0] bits;
    int n;
    if (e) begin bits = {stp[1], stp[0], p, d, 1'b0}; n = 12; end
    else   begin bits = {2'b11, stp[0], d, 1'b0};     n = 10; end
    for (int i = 0; i < n; i++) begin
      set_line(e, bits[i]);
      repeat (BIT_CLK) @(negedge clk);
    end
    set_line(e, 1'b1);
  endtask

  // Frame-level expectation {parity_err, frame_err, data}; even parity for dut_e.
  function automatic logic [9:0] model(input bit e, input logic [7:0] d, input logic p,
                                       input logic [1:0] stp);
    logic perr, ferr;
    perr = e && ((($countones(d) + int'(p)) % 2) != 0);
    ferr = e ? !(stp[0] && stp[1]) : !stp[0];
    return {perr, ferr, d};
  endfunction

  task automatic take_one(input bit e, input logic [9:0] exp, input string tag);
    logic [9:0] got;
    int sz;
    sz = e ? acc_e.size() : acc_n.size();
    check({tag, "_count"}, sz, 1);
    got = ~exp;
    if (sz > 0) got = e ? acc_e.pop_front() : acc_n.pop_front();
    check(tag, got, exp);
    acc_n.delete();
    acc_e.delete();
  endtask

  initial begin
    logic [7:0] ovd [OVR_FRAMES];
    logic [7:0] part;
    logic [9:0] got;
    int ov0, b0;

    repeat (3) @(negedge clk);
    check("reset_out_n", {v_n, busy_n, pe_n, fe_n, ov_n, bk_n, data_n}, 0);
    check("reset_out_e", {v_e, busy_e, pe_e, fe_e, ov_e, bk_e, data_e}, 0);
    rst_n = 1'b1;
    idle(1);

    // Basic 8N1 word, delivered before the stop bit ends.
    send(0, 8'hA5, 1'b0, 2'b11);
    take_one(0, {2'b00, 8'hA5}, "a5_word");
    check("a5_valid_cleared", v_n, 0);
    idle(2);

    // Even parity: 0x07 has three ones, so parity bit 0 is wrong, 1 is right.
    send(1, 8'h07, 1'b0, 2'b11);
    take_one(1, model(1, 8'h07, 1'b0, 2'b11), "par_bad");
    idle(2);
    send(1, 8'h07, 1'b1, 2'b11);
    take_one(1, model(1, 8'h07, 1'b1, 2'b11), "par_good");
    idle(2);

    // Random frames on both receivers, some with bad parity or stop bits.
    for (int k = 0; k < 10; k++) begin
      bit e;
      logic [7:0] d;
      logic p;
      logic [1:0] s;
      e = k[0];
      d = 8'($urandom);
      p = 1'($urandom);
      s = 2'b11;
      if ($urandom_range(0, 3) == 0) s = e ? 2'($urandom_range(0, 2)) : 2'b10;
      if (!s[0] && d == 8'h00) d = 8'h81;
      send(e, d, p, s);
      take_one(e, model(e, d, p, s), "rand_word");
      idle(2);
    end

    // Short low glitch: false start, no word.
    rxd_n = 1'b0;
    repeat (12) @(negedge clk);
    rxd_n = 1'b1;
    repeat (2) @(negedge clk);
    check("glitch_busy_hi", busy_n, 1);
    idle(1);
    check("glitch_busy_lo", busy_n, 0);
    check("glitch_no_word", acc_n.size(), 0);

    // Consumer stalled: extra frames beyond capacity are dropped.
    rdy_n = 1'b0;
    ov0 = cnt_ovr_n;
    for (int k = 0; k < OVR_FRAMES; k++) begin
      ovd[k] = (k == 0) ? 8'h11 : (k == 1) ? 8'h22 : 8'($urandom);
      send(0, ovd[k], 1'b0, 2'b11);
      idle(2);
      if (k == 0) check("ovr_none_yet", cnt_ovr_n - ov0, 0);
    end
    check("ovr_valid", v_n, 1);
    check("ovr_hold_data", data_n, 8'h11);
    check("ovr_pulses", cnt_ovr_n - ov0, 1);
    check("ovr_none_accepted", acc_n.size(), 0);
    rdy_n = 1'b1;
    repeat (20) @(negedge clk);
    check("ovr_drain_count", acc_n.size(), KEEP);
    for (int k = 0; k < KEEP; k++) begin
      got = 10'h3ff;
      if (acc_n.size() > 0) got = acc_n.pop_front();
      check("ovr_drain_word", got, {2'b00, ovd[k]});
    end
    acc_n.delete();

    // Break: line low for 20 bit times.
    b0 = cnt_brk_n;
    rxd_n = 1'b0;
    idle(20);
    rxd_n = 1'b1;
    idle(2);
    check("brk_pulse", cnt_brk_n - b0, 1);
    check("brk_no_word", acc_n.size(), 0);
    check("brk_busy_lo", busy_n, 0);
    send(0, 8'h3C, 1'b0, 2'b11);
    take_one(0, model(0, 8'h3C, 1'b0, 2'b11), "after_brk");
    idle(2);

    // Reset in the middle of data bit 4 with a word pending.
    rdy_n = 1'b0;
    send(0, 8'h42, 1'b0, 2'b11);
    idle(1);
    check("pre_rst_valid", v_n, 1);
    part = 8'h5A;
    rxd_n = 1'b0;
    repeat (BIT_CLK) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rxd_n = part[i];
      repeat (BIT_CLK) @(negedge clk);
    end
    rxd_n = part[4];
    repeat (BIT_CLK / 2) @(negedge clk);
    check("pre_rst_busy", busy_n, 1);
    rst_n = 1'b0;
    #1;
    check("rst_outputs", {v_n, busy_n, pe_n, fe_n, ov_n, bk_n, data_n}, 0);
    rxd_n = 1'b1;
    rdy_n = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    check("post_rst_no_word", acc_n.size(), 0);
    send(0, 8'h5A, 1'b0, 2'b11);
    take_one(0, model(0, 8'h5A, 1'b0, 2'b11), "post_rst_word");
    idle(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
- Parametrised UART receiver; next generation of the fixed 8N1 receiver.
- Adds configurable data width, parity, stop bits and oversampling; an integer baud divisor; 3-sample majority voting; parity, framing, break and overrun reporting; and a valid/ready output handshake.
- Sits between the board RxD pin and the host-command/debug logic.

Parameters:
CLK_DIV, 27, clk cycles per oversample tick (50 MHz / (115200*16)); legal range >=2
OVERSAMPLE, 16, ticks per bit; power of 2, 8..32
DATA_BITS, 8, data bits per frame, 5..9
PARITY, 0, 0=none, 1=odd, 2=even
STOP_BITS, 1, 1 or 2 stop bits checked
FIFO_DEPTH, 4, entries when UART_RX_FIFO_EN is defined; power of 2

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
rxd  in  1  serial line, idle high, asynchronous to clk
rx_data  out  DATA_BITS  received word, LSB first on the line
rx_parity_err  out  1  parity mismatch for the word on rx_data
rx_frame_err  out  1  a checked stop bit was sampled low for the word on rx_data
rx_valid  out  1  rx_data and error flags are valid
rx_ready  in  1  consumer accepts the word when rx_valid && rx_ready
rx_overrun  out  1  one-cycle pulse: a completed frame was dropped
rx_break  out  1  one-cycle pulse: break detected
rx_busy  out  1  high whenever the state machine is not in IDLE

Behaviour:
- Reset (async assert, sync release): all outputs 0; sync flops = 1; state IDLE; tick counter 0.
- Synchroniser: 2-flop synchroniser on every clk, then a 3-bit shift of samples taken on each tick. vote = majority of the 3 samples.
- Tick: counter runs 0..CLK_DIV-1; tick = (count==CLK_DIV-1). Free-running.
- Phase counter: counts ticks within a bit. Cleared on entry to START. Bit sample point is the tick where phase==OVERSAMPLE/2-1, and the vote is taken there.
- States: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE: on a tick with synced sample 0, go to START.
- START: at the sample point, vote=1 means false start and return to IDLE. vote=0 goes to DATA.
- DATA: at each sample point, shift vote in at the MSB (LSB-first). After DATA_BITS samples, go to PARITY if PARITY!=0, else STOP.
- PARITY: compare vote with the XOR of the data bits (odd: XOR^1). Record the mismatch.
- STOP: sample STOP_BITS stop bits. Any 0 sets the frame error.
- Frame end: after the last stop sample, return to IDLE immediately (mid-stop-bit) so the next start edge can resync.
- Break: data all 0, parity bit 0 if present, and first stop bit 0. Result is a rx_break pulse, no word is delivered, and the machine enters BREAK. It stays in BREAK until a tick sees synced sample 1, then goes to IDLE.
- Delivery: the word and flags are loaded into the output register one clk after the final stop sample.
- Handshake: rx_valid stays high until rx_valid && rx_ready.
- Full output, frame completes:
  - No FIFO: if rx_valid && !rx_ready, the new frame is dropped, rx_overrun pulses, and the old word is retained.
  - Completion in the same cycle as acceptance is not an overrun; the new word loads and rx_valid stays 1.
- Output register stability: rx_data and the error flags are stable while rx_valid=1 and rx_ready=0.
- Mid-frame reset: immediately returns to IDLE with outputs cleared; no partial word is delivered.

Optional Feature:
UART_RX_FIFO_EN:
- Defined: a FIFO of FIFO_DEPTH entries, each {data, parity_err, frame_err}, sits in front of the output.
  - rx_valid = !empty; the output shows the head entry.
  - A pop and a push in the same cycle are both honoured.
  - rx_overrun pulses only when a frame completes while the FIFO is full and no pop occurs; that frame is dropped.
- Undefined: single output register as described above.

Test Plan:
- CLK_DIV=4, OVERSAMPLE=8, 8N1, rx_ready=1; send 0xA5 at 32 clk/bit -> one rx_valid with rx_data=0xA5, both errors 0, delivered 1 clk after stop sample.
- PARITY=2; send 0x07 with parity bit 0 -> rx_data=0x07, rx_parity_err=1. Resend with parity bit 1 -> rx_parity_err=0.
- 12-clk low glitch on idle line -> false start, no rx_valid, rx_busy returns low within one bit time.
- Hold rx_ready=0 and send 0x11 then 0x22 -> rx_data stays 0x11 and rx_overrun pulses once. With UART_RX_FIFO_EN and FIFO_DEPTH=4, five frames -> four valid words, then one overrun.
- Hold rxd low for 20 bit times -> one rx_break pulse, no rx_valid. Then send 0x3C -> received correctly.
- Assert rst_n low in the middle of data bit 4 -> all outputs 0 immediately. Next frame 0x5A is received correctly.
